// File: rtl/reg_file_wb_sink.sv
// Architectural register file fed by the write-back port, with two bypassed
// read ports for decode and a per-register pending-write scoreboard.
module reg_file_wb_sink #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_wb_en,
    input  logic [IDX_W-1:0]  reg_wb_index,
    input  logic [DATA_W-1:0] reg_wb_data,
    input  logic [IDX_W-1:0]  rd_a_index,
    input  logic [IDX_W-1:0]  rd_b_index,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic              iss_valid,
    input  logic              iss_a_used,
    input  logic              iss_b_used,
    input  logic              iss_dest_en,
    input  logic [IDX_W-1:0]  iss_dest_index,
    output logic              iss_stall,
    output logic              sb_err
);

    localparam int unsigned NREG = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic [CNT_W-1:0]  cnt_d  [NREG];
    logic              sb_err_q;
    logic              sb_err_d;

    logic              wb_live;
    logic              wb_hits_a;
    logic              wb_hits_b;
    logic              wb_hits_dest;
    logic              src_a_ready;
    logic              src_b_ready;
    logic              dest_blocked;
    logic              stall;
    logic              accept;
    logic [NREG-1:0]   inc_vec;
    logic [NREG-1:0]   dec_vec;

    // Register 0 is hardwired: never written, never pending.
    assign wb_live      = reg_wb_en && (reg_wb_index != '0);
    assign wb_hits_a    = wb_live && (reg_wb_index == rd_a_index);
    assign wb_hits_b    = wb_live && (reg_wb_index == rd_b_index);
    assign wb_hits_dest = wb_live && (reg_wb_index == iss_dest_index);

    always_comb begin
        rd_a_data = regs_q[rd_a_index];
        if (rd_a_index == '0) begin
            rd_a_data = '0;
        end else if (wb_hits_a) begin
            rd_a_data = reg_wb_data;
        end
    end

    always_comb begin
        rd_b_data = regs_q[rd_b_index];
        if (rd_b_index == '0) begin
            rd_b_data = '0;
        end else if (wb_hits_b) begin
            rd_b_data = reg_wb_data;
        end
    end

    // A source whose last pending write retires this cycle is ready via the bypass.
    always_comb begin
        src_a_ready = !iss_a_used || (rd_a_index == '0) || (cnt_q[rd_a_index] == '0) ||
                      ((cnt_q[rd_a_index] == CNT_ONE) && wb_hits_a);
        src_b_ready = !iss_b_used || (rd_b_index == '0) || (cnt_q[rd_b_index] == '0) ||
                      ((cnt_q[rd_b_index] == CNT_ONE) && wb_hits_b);
        dest_blocked = iss_dest_en && (iss_dest_index != '0) &&
                       (cnt_q[iss_dest_index] == CNT_MAX) && !wb_hits_dest;
        stall  = iss_valid && (!src_a_ready || !src_b_ready || dest_blocked);
        accept = iss_valid && !stall;
    end

    assign iss_stall = stall;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            inc_vec[i] = accept && iss_dest_en && (iss_dest_index == IDX_W'(i));
            dec_vec[i] = reg_wb_en && (reg_wb_index == IDX_W'(i));
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_live) begin
            regs_d[reg_wb_index] = reg_wb_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (inc_vec[i] && !dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    always_comb begin
        sb_err_d = sb_err_q;
        if (wb_live && (cnt_q[reg_wb_index] == '0)) begin
            sb_err_d = 1'b1;
        end
    end

    assign sb_err = sb_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q   <= '{default: '0};
            cnt_q    <= '{default: '0};
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: tb/tb_reg_file_wb_sink.sv
// Directed bench for reg_file_wb_sink: reads, bypass, scoreboard stalls,
// saturation, underflow error and asynchronous reset.
module tb_reg_file_wb_sink;

    logic        clk;
    logic        rst_n;
    logic        reg_wb_en;
    logic [5:0]  reg_wb_index;
    logic [63:0] reg_wb_data;
    logic [5:0]  rd_a_index;
    logic [5:0]  rd_b_index;
    logic [63:0] rd_a_data;
    logic [63:0] rd_b_data;
    logic        iss_valid;
    logic        iss_a_used;
    logic        iss_b_used;
    logic        iss_dest_en;
    logic [5:0]  iss_dest_index;
    logic        iss_stall;
    logic        sb_err;

    int unsigned n_checks;
    int unsigned n_errors;

    reg_file_wb_sink #(
        .DATA_W(64),
        .IDX_W (6),
        .CNT_W (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .reg_wb_en     (reg_wb_en),
        .reg_wb_index  (reg_wb_index),
        .reg_wb_data   (reg_wb_data),
        .rd_a_index    (rd_a_index),
        .rd_b_index    (rd_b_index),
        .rd_a_data     (rd_a_data),
        .rd_b_data     (rd_b_data),
        .iss_valid     (iss_valid),
        .iss_a_used    (iss_a_used),
        .iss_b_used    (iss_b_used),
        .iss_dest_en   (iss_dest_en),
        .iss_dest_index(iss_dest_index),
        .iss_stall     (iss_stall),
        .sb_err        (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        reg_wb_en      = 1'b0;
        reg_wb_index   = '0;
        reg_wb_data    = '0;
        rd_a_index     = '0;
        rd_b_index     = '0;
        iss_valid      = 1'b0;
        iss_a_used     = 1'b0;
        iss_b_used     = 1'b0;
        iss_dest_en    = 1'b0;
        iss_dest_index = '0;
    endtask

    task automatic wb(input logic [5:0] idx, input logic [63:0] data);
        reg_wb_en    = 1'b1;
        reg_wb_index = idx;
        reg_wb_data  = data;
    endtask

    task automatic issue(input logic a_used, input logic [5:0] a_idx,
                         input logic b_used, input logic [5:0] b_idx,
                         input logic dest_en, input logic [5:0] dest);
        iss_valid      = 1'b1;
        iss_a_used     = a_used;
        rd_a_index     = a_idx;
        iss_b_used     = b_used;
        rd_b_index     = b_idx;
        iss_dest_en    = dest_en;
        iss_dest_index = dest;
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Reset state; issue dest r5 so the later write-back to r5 is legitimate
        issue(1'b1, 6'd5, 1'b1, 6'd0, 1'b1, 6'd5);
        #1;
        check("rst_rd_a", rd_a_data, 64'h0);
        check("rst_rd_b", rd_b_data, 64'h0);
        check("rst_sb_err", {63'h0, sb_err}, 64'h0);
        check("rst_stall", {63'h0, iss_stall}, 64'h0);
        tick();

        // Write-back r5 with bypass; a reader of r5 (cnt=1) is ready this cycle
        set_idle();
        wb(6'd5, 64'hDEADBEEF_00000001);
        issue(1'b1, 6'd5, 1'b0, 6'd0, 1'b0, 6'd0);
        #1;
        check("bypass_r5", rd_a_data, 64'hDEADBEEF_00000001);
        check("retire_ready_r5", {63'h0, iss_stall}, 64'h0);
        tick();

        set_idle();
        rd_a_index = 6'd5;
        rd_b_index = 6'd5;
        #1;
        check("stored_r5_a", rd_a_data, 64'hDEADBEEF_00000001);
        check("stored_r5_b", rd_b_data, 64'hDEADBEEF_00000001);
        check("no_err_r5", {63'h0, sb_err}, 64'h0);
        tick();

        // Register 0: write discarded, destination r0 not tracked
        set_idle();
        wb(6'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd0);
        #1;
        check("r0_bypass_zero", rd_a_data, 64'h0);
        tick();

        set_idle();
        issue(1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 6'd0);
        #1;
        check("r0_stored_zero", rd_a_data, 64'h0);
        check("r0_no_stall", {63'h0, iss_stall}, 64'h0);
        check("r0_no_err", {63'h0, sb_err}, 64'h0);
        tick();

        // RAW on r7
        set_idle();
        issue(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd7);
        tick();
        set_idle();
        issue(1'b1, 6'd7, 1'b0, 6'd0, 1'b0, 6'd0);
        #1;
        check("raw_r7_stall", {63'h0, iss_stall}, 64'h1);
        tick();
        wb(6'd7, 64'h42);
        #1;
        check("raw_r7_release", {63'h0, iss_stall}, 64'h0);
        check("raw_r7_data", rd_a_data, 64'h42);
        tick();
        set_idle();
        issue(1'b1, 6'd7, 1'b0, 6'd0, 1'b0, 6'd0);
        #1;
        check("r7_drained", {63'h0, iss_stall}, 64'h0);
        tick();

        // WAW saturation on r9 (max 3 in flight)
        set_idle();
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd9);
            #1;
            check($sformatf("waw_r9_issue%0d", i), {63'h0, iss_stall}, 64'h0);
            tick();
        end
        issue(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd9);
        #1;
        check("waw_r9_full", {63'h0, iss_stall}, 64'h1);
        tick();
        wb(6'd9, 64'h9);
        #1;
        check("waw_r9_wb_accept", {63'h0, iss_stall}, 64'h0);
        tick();
        set_idle();
        issue(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd9);
        #1;
        check("waw_r9_still_full", {63'h0, iss_stall}, 64'h1);
        tick();

        // Issue dest r3 and retire r3 in the same cycle keeps cnt at 1
        set_idle();
        issue(1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd3);
        tick();
        wb(6'd3, 64'h33);
        #1;
        check("r3_inc_dec_accept", {63'h0, iss_stall}, 64'h0);
        tick();
        set_idle();
        issue(1'b0, 6'd0, 1'b1, 6'd3, 1'b0, 6'd0);
        #1;
        check("r3_reader_stall", {63'h0, iss_stall}, 64'h1);
        check("r3_data", rd_b_data, 64'h33);
        check("pre_underflow_err", {63'h0, sb_err}, 64'h0);
        tick();

        // Underflow on r12
        set_idle();
        wb(6'd12, 64'h1234);
        rd_a_index = 6'd12;
        #1;
        check("r12_bypass", rd_a_data, 64'h1234);
        tick();
        set_idle();
        rd_a_index = 6'd12;
        rd_b_index = 6'd5;
        #1;
        check("r12_stored", rd_a_data, 64'h1234);
        check("underflow_err", {63'h0, sb_err}, 64'h1);
        tick();
        #1;
        check("underflow_sticky", {63'h0, sb_err}, 64'h1);

        // Asynchronous reset mid-cycle; r9 pending state must vanish
        issue(1'b1, 6'd12, 1'b1, 6'd9, 1'b0, 6'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_err", {63'h0, sb_err}, 64'h0);
        check("async_rst_rd_a", rd_a_data, 64'h0);
        check("async_rst_stall", {63'h0, iss_stall}, 64'h0);
        rd_b_index = 6'd5;
        #1;
        check("async_rst_rd_b", rd_b_data, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // A write-back left over from before reset is an underflow
        set_idle();
        wb(6'd5, 64'h55);
        tick();
        set_idle();
        #1;
        check("post_rst_wb_err", {63'h0, sb_err}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
